stopwatch_ctrl: RTL and testbench

Control front-end for the two-digit 0–99 display counter. It conditions two raw active-low push-buttons: synchronises, debounces and edge-detects them. It keeps a run/pause state machine and divides the system clock into a one-cycle count-enable tick. Its three outputs are `EN`, `RUN` and `CLR_N`, which drive the counter's enable, pause and clear inputs directly.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/stopwatch_ctrl.sv | 92 +++++++++
 tb/tb_stopwatch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and default constants for the stopwatch control front-end.
// FSM state, button indices and the 50 MHz timing defaults live here.
package stopwatch_pkg;

    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_RUNNING = 1'b1
    } sw_state_e;

    // 10 Hz tick and 5 ms debounce at a 50 MHz system clock
    localparam int TICK_DIV_50M = 5000000;
    localparam int DB_5MS_50M   = 250000;

    localparam int NUM_BTNS = 2;
    localparam int BTN_RUN  = 0;
    localparam int BTN_CLR  = 1;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stable-count debounce and
// a one-cycle press pulse on the debounced 1->0 transition.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_5MS_50M
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn_raw_n,
    output logic db_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt;

    // Any disagreement between s2 and the accepted level restarts the count,
    // so only an unbroken run of DB_CYCLES samples moves db_q.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            db_q <= 1'b1;
            db_d <= 1'b1;
            cnt  <= '0;
        end else begin
            s1   <= btn_raw_n;
            s2   <= s1;
            db_d <= db_q;
            if (s2 == db_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db_q <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign db_n  = db_q;
    assign press = db_d & ~db_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions run/clear buttons, runs the pause/run FSM and
// divides CLK into the one-cycle EN tick for the 0-99 display counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_50M,
    parameter int DB_CYCLES = DB_5MS_50M
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_RUN_N,
    input  logic BTN_CLR_N,
    output logic EN,
    output logic RUN,
    output logic CLR_N
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TC_LAST = TW'(TICK_DIV - 1);

    logic [NUM_BTNS-1:0] btn_raw_n;
    logic [NUM_BTNS-1:0] db_n;
    logic [NUM_BTNS-1:0] press;

    sw_state_e     state_q;
    sw_state_e     state_d;
    logic          clr_q;
    logic          en_q;
    logic [TW-1:0] tcnt;

    // The run button only matters through its press pulse
    logic unused_run_lvl;

    assign btn_raw_n[BTN_RUN] = BTN_RUN_N;
    assign btn_raw_n[BTN_CLR] = BTN_CLR_N;
    assign unused_run_lvl     = db_n[BTN_RUN];

    genvar g;
    generate
        for (g = 0; g < NUM_BTNS; g++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .CLK      (CLK),
                .RST_N    (RST_N),
                .btn_raw_n(btn_raw_n[g]),
                .db_n     (db_n[g]),
                .press    (press[g])
            );
        end
    endgenerate

    // Clear outranks a simultaneous run press
    always_comb begin
        state_d = state_q;
        if (press[BTN_CLR]) begin
            state_d = ST_PAUSED;
        end else if (press[BTN_RUN]) begin
            state_d = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_PAUSED;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            clr_q   <= db_n[BTN_CLR];
        end
    end

    // tcnt holds while paused so a resume keeps the tick phase
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tcnt <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= clr_q && (state_q == ST_RUNNING) && (tcnt == TC_LAST);
            if (!clr_q) begin
                tcnt <= '0;
            end else if (state_q == ST_RUNNING) begin
                tcnt <= (tcnt == TC_LAST) ? '0 : tcnt + 1'b1;
            end
        end
    end

    assign RUN   = (state_q == ST_RUNNING);
    assign CLR_N = clr_q;
    assign EN    = en_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3: expected output
// events (edge-stamped) are queued with the stimulus and matched as they occur.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam logic [7:0] EV_EN  = 8'd1;
    localparam logic [7:0] EV_RUN = 8'd2;
    localparam logic [7:0] EV_CLR = 8'd3;

    logic CLK;
    logic RST_N;
    logic BTN_RUN_N;
    logic BTN_CLR_N;
    logic EN;
    logic RUN;
    logic CLR_N;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        mon_en;
    logic        p_run = 1'b0;
    logic        p_clr = 1'b1;
    logic [47:0] exp_q[$];

    stopwatch_ctrl #(
        .TICK_DIV (TD),
        .DB_CYCLES(DB)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_RUN_N(BTN_RUN_N),
        .BTN_CLR_N(BTN_CLR_N),
        .EN       (EN),
        .RUN      (RUN),
        .CLR_N    (CLR_N)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event word: {kind, 7'b0, value, edge number}
    task automatic push_ev(input logic [7:0] k, input logic v, input int c);
        exp_q.push_back({k, 7'b0, v, c});
    endtask

    task automatic push_en(input int first, input int last);
        for (int c = first; c <= last; c += TD) push_ev(EV_EN, 1'b1, c);
    endtask

    task automatic obs_ev(input logic [7:0] k, input logic v);
        logic [47:0] o;
        o = {k, 7'b0, v, cyc};
        if (exp_q.size() == 0) chk("unexpected_event", o, 48'd0);
        else chk("event", o, exp_q.pop_front());
    endtask

    // Edge-stamped monitor; checks EN, then RUN, then CLR_N within a cycle
    always @(negedge CLK) begin
        if (mon_en) begin
            if (EN) obs_ev(EV_EN, 1'b1);
            if (RUN !== p_run) obs_ev(EV_RUN, RUN);
            if (CLR_N !== p_clr) obs_ev(EV_CLR, CLR_N);
        end
        p_run <= RUN;
        p_clr <= CLR_N;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_pend(input string tag);
        chk(tag, 48'(exp_q.size()), 48'd0);
        exp_q.delete();
    endtask

    initial begin
        CLK = 1'b0;
        RST_N = 1'b1;
        BTN_RUN_N = 1'b1;
        BTN_CLR_N = 1'b1;
        mon_en = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        chk("rst_en", 48'(EN), 48'd0);
        chk("rst_run", 48'(RUN), 48'd0);
        chk("rst_clr_n", 48'(CLR_N), 48'd1);
        wait_cyc(3);
        RST_N = 1'b1;
        mon_en = 1'b1;

        // Idle: no events at all
        wait_cyc(53);
        chk("idle_run", 48'(RUN), 48'd0);
        chk("idle_clr_n", 48'(CLR_N), 48'd1);
        chk_pend("idle_pending");

        // Glitches of 2 samples are dropped
        wait_cyc(59); BTN_RUN_N = 1'b0;
        wait_cyc(61); BTN_RUN_N = 1'b1;
        wait_cyc(66); BTN_RUN_N = 1'b0;
        wait_cyc(68); BTN_RUN_N = 1'b1;
        wait_cyc(85);
        chk("glitch_run", 48'(RUN), 48'd0);
        chk_pend("glitch_pending");

        // Start (s1 low at 90 -> RUN at 95), then pause with tcnt=2 at 113
        push_ev(EV_RUN, 1'b1, 95);
        push_en(99, 111);
        push_ev(EV_RUN, 1'b0, 113);
        wait_cyc(89);  BTN_RUN_N = 1'b0;
        wait_cyc(99);  BTN_RUN_N = 1'b1;
        wait_cyc(107); BTN_RUN_N = 1'b0;
        wait_cyc(113); BTN_RUN_N = 1'b1;
        wait_cyc(120);
        chk("paused_run", 48'(RUN), 48'd0);
        chk_pend("pause_pending");

        // Resume at 127 (first EN 2 later); clear+run together at 136 lands
        // on an EN edge, clear wins, tick at 141 still delivered
        push_ev(EV_RUN, 1'b1, 127);
        push_en(129, 141);
        push_ev(EV_RUN, 1'b0, 141);
        push_ev(EV_CLR, 1'b0, 141);
        push_ev(EV_CLR, 1'b1, 149);
        wait_cyc(121); BTN_RUN_N = 1'b0;
        wait_cyc(127); BTN_RUN_N = 1'b1;
        wait_cyc(135); BTN_RUN_N = 1'b0; BTN_CLR_N = 1'b0;
        wait_cyc(143); BTN_RUN_N = 1'b1; BTN_CLR_N = 1'b1;
        wait_cyc(145);
        chk("clr_held_clr_n", 48'(CLR_N), 48'd0);
        chk("clr_held_run", 48'(RUN), 48'd0);
        wait_cyc(152);
        chk_pend("clear_pending");

        // Run after clear: tcnt was zeroed, first EN a full period later
        push_ev(EV_RUN, 1'b1, 160);
        push_en(164, 164);
        wait_cyc(154); BTN_RUN_N = 1'b0;
        wait_cyc(159); BTN_RUN_N = 1'b1;
        wait_cyc(164); BTN_CLR_N = 1'b0;

        // Async reset with clear count at 2 and EN high
        wait_cyc(168);
        mon_en = 1'b0;
        chk_pend("prereset_pending");
        chk("prereset_en", 48'(EN), 48'd1);
        RST_N = 1'b0;
        #1;
        chk("async_en", 48'(EN), 48'd0);
        chk("async_run", 48'(RUN), 48'd0);
        chk("async_clr_n", 48'(CLR_N), 48'd1);
        push_ev(EV_CLR, 1'b0, 176);
        push_ev(EV_CLR, 1'b1, 185);
        wait_cyc(170);
        RST_N = 1'b1;
        mon_en = 1'b1;
        wait_cyc(179); BTN_CLR_N = 1'b1;
        wait_cyc(195);
        chk("final_run", 48'(RUN), 48'd0);
        chk("final_clr_n", 48'(CLR_N), 48'd1);
        chk_pend("final_pending");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
